// File: rtl/ro_meas_pkg.sv
// Shared types and default widths for the ring-oscillator frequency meter.
package ro_meas_pkg;

   localparam int unsigned CNT_W_DEF = 16;
   localparam int unsigned WIN_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/ro_sync.sv
// Two-flop synchronizer for the asynchronous ring-oscillator output plus rising-edge detect.
module ro_sync (
   input  logic ck,
   input  logic nrst,
   input  logic ro,
   output logic rise
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= ro;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/ro_meas.sv
// Ring-oscillator frequency meter: counts synchronized ro rising edges over a window of ck cycles.
module ro_meas
   import ro_meas_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned WIN_W = WIN_W_DEF
) (
   input  logic             ck,
   input  logic             nrst,
   input  logic             ro,
   input  logic             start,
   input  logic             abort,
   input  logic [WIN_W-1:0] win,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   state_e           state_q, state_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [WIN_W-1:0] wcnt_q, wcnt_d;
   logic             arm_q, arm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             rise;

   ro_sync u_sync (
      .ck   (ck),
      .nrst (nrst),
      .ro   (ro),
      .rise (rise)
   );

   // Next-state and output decode; abort overrides everything, including start in IDLE.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      wcnt_d  = wcnt_q;
      arm_d   = arm_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (abort) begin
         state_d = IDLE;
         win_d   = '0;
         wcnt_d  = '0;
         arm_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = ARM;
                  win_d   = win;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  arm_d   = 1'b0;
               end
            end
            ARM: begin
               // arm_q marks the second of the two ARM cycles
               if (!arm_q) begin
                  arm_d = 1'b1;
               end else begin
                  arm_d = 1'b0;
                  if (win_q == '0) begin
                     state_d = DONE;
                  end else begin
                     state_d = COUNT;
                     wcnt_d  = win_q;
                  end
               end
            end
            COUNT: begin
               if (rise) begin
                  if (cnt_q == {CNT_W{1'b1}}) ovf_d = 1'b1;
                  else                        cnt_d = cnt_q + CNT_W'(1);
               end
               if (wcnt_q == WIN_W'(1)) begin
                  state_d = DONE;
                  wcnt_d  = '0;
               end else begin
                  wcnt_d  = wcnt_q - WIN_W'(1);
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d == ARM) || (state_d == COUNT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge ck or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         win_q   <= '0;
         wcnt_q  <= '0;
         arm_q   <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         wcnt_q  <= wcnt_d;
         arm_q   <= arm_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign cnt  = cnt_q;
   assign ovf  = ovf_q;

endmodule
